// File: rtl/decode_pipe_reg.sv
// Decode-stage pipeline register: a main entry driving the outputs plus a skid entry,
// so IN_READY comes straight from a flop and never depends on OUT_READY.
module decode_pipe_reg #(
  parameter int ALU_W = 4,
  parameter int WAD_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             AR_IN,
  input  logic             BR_IN,
  input  logic [ALU_W-1:0] ALU_IN,
  input  logic             input_IN,
  input  logic             wren_IN,
  input  logic [WAD_W-1:0] writeAd_IN,
  input  logic [WAD_W-1:0] ADR_MUX_IN,
  input  logic             write_IN,
  input  logic             PC_load_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             AR_OUT,
  output logic             BR_OUT,
  output logic [ALU_W-1:0] ALU_OUT,
  output logic             input_OUT,
  output logic             wren_OUT,
  output logic [WAD_W-1:0] writeAd_OUT,
  output logic [WAD_W-1:0] ADR_MUX_OUT,
  output logic             write_OUT,
  output logic             PC_load_OUT,
  output logic [1:0]       OCCUPANCY,
  output logic [CNT_W-1:0] BUBBLE_CNT
);

  localparam int PW = 6 + ALU_W + 2 * WAD_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [PW-1:0] in_pay, m_pay, s_pay, m_pay_nxt, s_pay_nxt;
  logic          m_vld, s_vld, m_vld_nxt, s_vld_nxt;
  logic          in_rdy;
  logic          accept, drain;
  logic          m_wren, m_write, m_pc_load;

  assign in_pay = {AR_IN, BR_IN, ALU_IN, input_IN, wren_IN, writeAd_IN, ADR_MUX_IN,
                   write_IN, PC_load_IN};
  assign {AR_OUT, BR_OUT, ALU_OUT, input_OUT, m_wren, writeAd_OUT, ADR_MUX_OUT,
          m_write, m_pc_load} = m_pay;

  assign IN_READY  = in_rdy;
  assign OUT_VALID = m_vld;
  assign accept    = IN_VALID & in_rdy;
  assign drain     = m_vld & OUT_READY;

  // Side-effect strobes are gated so an empty slot can never write or branch.
  assign wren_OUT    = m_wren & m_vld;
  assign write_OUT   = m_write & m_vld;
  assign PC_load_OUT = m_pc_load & m_vld;

  always_comb begin
    m_vld_nxt = m_vld;
    s_vld_nxt = s_vld;
    m_pay_nxt = m_pay;
    s_pay_nxt = s_pay;
    if (FLUSH) begin
      m_vld_nxt = 1'b0;
      s_vld_nxt = 1'b0;
    end else if (!m_vld || drain) begin
      // The skid entry is older than anything on the input, so it goes first.
      if (s_vld) begin
        m_pay_nxt = s_pay;
        m_vld_nxt = 1'b1;
      end else if (accept) begin
        m_pay_nxt = in_pay;
        m_vld_nxt = 1'b1;
      end else begin
        m_vld_nxt = 1'b0;
      end
      s_vld_nxt = 1'b0;
    end else if (accept) begin
      s_pay_nxt = in_pay;
      s_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      m_vld      <= 1'b0;
      s_vld      <= 1'b0;
      m_pay      <= '0;
      s_pay      <= '0;
      in_rdy     <= 1'b1;
      OCCUPANCY  <= 2'd0;
      BUBBLE_CNT <= '0;
    end else begin
      m_vld     <= m_vld_nxt;
      s_vld     <= s_vld_nxt;
      m_pay     <= m_pay_nxt;
      s_pay     <= s_pay_nxt;
      in_rdy    <= ~s_vld_nxt;
      OCCUPANCY <= {1'b0, m_vld_nxt} + {1'b0, s_vld_nxt};
      if (OUT_READY && !m_vld)
        BUBBLE_CNT <= sat_inc(BUBBLE_CNT);
    end
  end

endmodule

// File: tb/tb_decode_pipe_reg.sv
// Directed bench for decode_pipe_reg: pass-through, skid stall, bubble masking,
// flush, saturating bubble counter and mid-stream reset.
module tb_decode_pipe_reg;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic       ar_in, br_in, input_in, wren_in, write_in, pc_load_in;
  logic [3:0] alu_in;
  logic [2:0] write_ad_in, adr_mux_in;
  logic       ar_out, br_out, input_out, wren_out, write_out, pc_load_out;
  logic [3:0] alu_out;
  logic [2:0] write_ad_out, adr_mux_out;
  logic [1:0] occupancy;
  logic [1:0] bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_pipe_reg #(.ALU_W(4), .WAD_W(3), .CNT_W(2)) dut (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .AR_IN(ar_in), .BR_IN(br_in), .ALU_IN(alu_in), .input_IN(input_in),
    .wren_IN(wren_in), .writeAd_IN(write_ad_in), .ADR_MUX_IN(adr_mux_in),
    .write_IN(write_in), .PC_load_IN(pc_load_in),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .AR_OUT(ar_out), .BR_OUT(br_out), .ALU_OUT(alu_out), .input_OUT(input_out),
    .wren_OUT(wren_out), .writeAd_OUT(write_ad_out), .ADR_MUX_OUT(adr_mux_out),
    .write_OUT(write_out), .PC_load_OUT(pc_load_out),
    .OCCUPANCY(occupancy), .BUBBLE_CNT(bubble_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags = {ar, br, input, wren, write, pc_load}
  task automatic drive(input logic v, input logic [3:0] alu, input logic [2:0] wad,
                       input logic [5:0] flags);
    in_valid    = v;
    alu_in      = alu;
    write_ad_in = wad;
    adr_mux_in  = ~wad;
    {ar_in, br_in, input_in, wren_in, write_in, pc_load_in} = flags;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    flush     = 1'b0;
    drive(1'b1, 4'hF, 3'h7, 6'h3F);
    do_reset();
    drive(1'b0, 4'h0, 3'h0, 6'h00);
    n_vec++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (bubble_cnt !== 2'd0) begin n_err++; $display("FAIL reset_bubble: got %0d want 0", bubble_cnt); end
    n_vec++; if (alu_out !== 4'h0 || write_ad_out !== 3'h0 || ar_out !== 1'b0)
      begin n_err++; $display("FAIL reset_payload: got alu=%h wad=%h ar=%b want 0", alu_out, write_ad_out, ar_out); end
  endtask

  task automatic test_bubble_cnt();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (bubble_cnt !== exp_cnt[i])
        begin n_err++; $display("FAIL bubble_cnt[%0d]: got %0d want %0d", i, bubble_cnt, exp_cnt[i]); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_pass_through();
    out_ready = 1'b1;
    drive(1'b1, 4'h5, 3'h2, 6'h00);
    tick();
    drive(1'b0, 4'h0, 3'h0, 6'h00);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pass_valid: got %b want 1", out_valid); end
    n_vec++; if (alu_out !== 4'h5) begin n_err++; $display("FAIL pass_alu: got %h want 5", alu_out); end
    n_vec++; if (write_ad_out !== 3'h2 || adr_mux_out !== 3'h5)
      begin n_err++; $display("FAIL pass_addr: got wad=%h mux=%h want 2/5", write_ad_out, adr_mux_out); end
    n_vec++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL pass_occ: got %0d want 1", occupancy); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin n_err++; $display("FAIL pass_drained: got valid=%b occ=%0d want 0/0", out_valid, occupancy); end
    out_ready = 1'b0;
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 3'h1, 6'h00);
    tick();
    n_vec++; if (occupancy !== 2'd1 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL skid_a: got occ=%0d rdy=%b want 1/1", occupancy, in_ready); end
    drive(1'b1, 4'h2, 3'h3, 6'h00);
    tick();
    n_vec++; if (occupancy !== 2'd2 || in_ready !== 1'b0)
      begin n_err++; $display("FAIL skid_full: got occ=%0d rdy=%b want 2/0", occupancy, in_ready); end
    n_vec++; if (alu_out !== 4'h1) begin n_err++; $display("FAIL skid_head: got %h want 1", alu_out); end
    drive(1'b1, 4'h7, 3'h7, 6'h00);
    tick();
    n_vec++; if (occupancy !== 2'd2 || alu_out !== 4'h1)
      begin n_err++; $display("FAIL skid_refuse: got occ=%0d alu=%h want 2/1", occupancy, alu_out); end
    drive(1'b0, 4'h0, 3'h0, 6'h00);
    out_ready = 1'b1;
    n_vec++; if (alu_out !== 4'h1 || out_valid !== 1'b1)
      begin n_err++; $display("FAIL skid_out_a: got alu=%h valid=%b want 1/1", alu_out, out_valid); end
    tick();
    n_vec++; if (alu_out !== 4'h2 || write_ad_out !== 3'h3 || out_valid !== 1'b1)
      begin n_err++; $display("FAIL skid_out_b: got alu=%h wad=%h valid=%b want 2/3/1", alu_out, write_ad_out, out_valid); end
    n_vec++; if (occupancy !== 2'd1 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL skid_release: got occ=%0d rdy=%b want 1/1", occupancy, in_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin n_err++; $display("FAIL skid_empty: got valid=%b occ=%0d want 0/0", out_valid, occupancy); end
    out_ready = 1'b0;
  endtask

  task automatic test_bubble_mask();
    out_ready = 1'b1;
    drive(1'b1, 4'h9, 3'h4, 6'b000111);
    tick();
    drive(1'b0, 4'h0, 3'h0, 6'h00);
    n_vec++; if ({wren_out, write_out, pc_load_out} !== 3'b111)
      begin n_err++; $display("FAIL mask_live: got %b want 111", {wren_out, write_out, pc_load_out}); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mask_valid: got %b want 0", out_valid); end
    n_vec++; if ({wren_out, write_out, pc_load_out} !== 3'b000)
      begin n_err++; $display("FAIL mask_bubble: got %b want 000", {wren_out, write_out, pc_load_out}); end
    n_vec++; if (alu_out !== 4'h9) begin n_err++; $display("FAIL mask_stale_payload: got %h want 9", alu_out); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 4'h3, 3'h1, 6'h00);
    tick();
    drive(1'b1, 4'h4, 3'h2, 6'h00);
    tick();
    n_vec++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
    drive(1'b1, 4'h6, 3'h3, 6'h00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 4'h0, 3'h0, 6'h00);
    n_vec++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL flush_full: got occ=%0d valid=%b rdy=%b want 0/0/1", occupancy, out_valid, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (out_valid !== 1'b0)
        begin n_err++; $display("FAIL flush_ghost[%0d]: got valid=%b alu=%h want valid 0", i, out_valid, alu_out); end
    end
    // Single held entry: the incoming beat is really accepted, yet must vanish.
    out_ready = 1'b0;
    drive(1'b1, 4'hA, 3'h1, 6'h00);
    tick();
    drive(1'b1, 4'hB, 3'h2, 6'h00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 4'h0, 3'h0, 6'h00);
    n_vec++; if (occupancy !== 2'd0 || out_valid !== 1'b0)
      begin n_err++; $display("FAIL flush_accept_occ: got occ=%0d valid=%b want 0/0", occupancy, out_valid); end
    out_ready = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin n_err++; $display("FAIL flush_accept_drop: got valid=%b occ=%0d want 0/0", out_valid, occupancy); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i + 8), 3'(i), 6'h00);
      tick();
      n_vec++; if (out_valid !== 1'b1 || alu_out !== 4'(i + 8) || occupancy !== 2'd1 || in_ready !== 1'b1)
        begin n_err++; $display("FAIL b2b[%0d]: got valid=%b alu=%h occ=%0d rdy=%b want 1/%h/1/1",
                               i, out_valid, alu_out, occupancy, in_ready, 4'(i + 8)); end
    end
    drive(1'b0, 4'h0, 3'h0, 6'h00);
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive(1'b1, 4'hC, 3'h5, 6'h3F);
    tick();
    drive(1'b1, 4'hD, 3'h6, 6'h3F);
    tick();
    n_vec++; if (occupancy !== 2'd2 || bubble_cnt !== 2'd3)
      begin n_err++; $display("FAIL midrst_pre: got occ=%0d bub=%0d want 2/3", occupancy, bubble_cnt); end
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    rst_n = 1'b1;
    flush = 1'b0;
    drive(1'b0, 4'h0, 3'h0, 6'h00);
    n_vec++; if (occupancy !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_err++; $display("FAIL midrst_ctrl: got occ=%0d rdy=%b valid=%b want 0/1/0", occupancy, in_ready, out_valid); end
    n_vec++; if (bubble_cnt !== 2'd0) begin n_err++; $display("FAIL midrst_bubble: got %0d want 0", bubble_cnt); end
    n_vec++; if ({ar_out, br_out, alu_out, input_out, write_ad_out, adr_mux_out} !== 16'h0000)
      begin n_err++; $display("FAIL midrst_payload: got alu=%h wad=%h mux=%h want 0", alu_out, write_ad_out, adr_mux_out); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin n_err++; $display("FAIL midrst_discard: got valid=%b occ=%0d want 0/0", out_valid, occupancy); end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'h0, 3'h0, 6'h00);
    test_reset();
    test_bubble_cnt();
    test_pass_through();
    test_skid();
    test_bubble_mask();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
